// File: rtl/tl_ul_pkg.sv
// ---------------------------------------------------------------------------
// tl_ul_pkg
// Shared TileLink-UL definitions for the SRAM responder:
//   - A-channel request opcodes and D-channel response opcodes
//   - resp_t: response queue entry minus the source ID. The source width is a
//     parameter of the top, so the top prepends it when it packs an entry.
//   - byte_merge(): merges write data into a word under a byte-lane mask
// ---------------------------------------------------------------------------
package tl_ul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ARITHMETIC_DATA = 3'd2;
  localparam logic [2:0] LOGICAL_DATA    = 3'd3;
  localparam logic [2:0] GET             = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } resp_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tl_ul_resp_fifo.sv
// ---------------------------------------------------------------------------
// tl_ul_resp_fifo
// Two-entry FIFO for D-channel responses. The head entry drives o_data
// directly from a register, so the output stays stable while it is not being
// popped. o_full depends only on the registered count, which means nothing on
// the pop side can reach o_full combinationally.
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset (flushes queue)
//   i_push, i_data     : enqueue request and payload (dropped when full)
//   o_full             : two entries held
//   o_valid, o_data    : head entry valid and payload
//   i_pop              : dequeue the head (ignored when empty)
// ---------------------------------------------------------------------------
module tl_ul_resp_fifo #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_pop
);

  logic [W-1:0] r_entry [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = i_push && (r_count != 2'd2);
  assign w_pop_ok  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // Entries are cleared as well, so the D outputs read as zero after reset
      for (int e = 0; e < 2; e++) r_entry[e] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_entry[r_wr_ptr] <= i_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_entry[r_rd_ptr];

endmodule

// File: rtl/tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder
// TileLink-UL manager backed by a word-addressed flop-array SRAM of DEPTH
// 32-bit words at byte address BASE. It accepts Get, PutFullData and
// PutPartialData and answers through a 2-entry response queue.
// Ports:
//   i_clock, i_reset_n  : clock, asynchronous active-low reset
//   i_a_*  / o_a_ready  : TL-UL channel A (request); i_a_param is ignored
//   o_d_*  / i_d_ready  : TL-UL channel D (response) from the queue head
// Parameters: BASE (DEPTH*4-aligned), DEPTH (power of two), SOURCE_W.
// ---------------------------------------------------------------------------
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h2000_0000,
  parameter int          DEPTH    = 256,
  parameter int          SOURCE_W = 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [2:0]          i_a_opcode,
  input  logic [2:0]          i_a_param,
  input  logic [1:0]          i_a_size,
  input  logic [SOURCE_W-1:0] i_a_source,
  input  logic [31:0]         i_a_address,
  input  logic [3:0]          i_a_mask,
  input  logic [31:0]         i_a_data,
  output logic                o_d_valid,
  input  logic                i_d_ready,
  output logic [2:0]          o_d_opcode,
  output logic [1:0]          o_d_param,
  output logic [1:0]          o_d_size,
  output logic [SOURCE_W-1:0] o_d_source,
  output logic                o_d_denied,
  output logic                o_d_corrupt,
  output logic [31:0]         o_d_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $bits(resp_t);
  localparam int PW = SOURCE_W + RW;

  logic [31:0] r_mem [DEPTH];

  logic          w_fifo_full;
  logic          w_a_fire;
  logic          w_in_range;
  logic [1:0]    w_align_mask;
  logic          w_aligned;
  logic          w_size_ok;
  logic          w_op_ok;
  logic          w_denied;
  logic          w_data_op;
  logic          w_wr_en;
  logic [AW-1:0] w_index;
  logic [31:0]   w_rd_word;
  resp_t         w_resp;
  resp_t         w_head_resp;
  logic [PW-1:0] w_head_payload;
  logic          w_unused;

  assign o_a_ready = ~w_fifo_full;
  assign w_a_fire  = i_a_valid & o_a_ready;

  // BASE is DEPTH*4-aligned, so the window is exactly the addresses whose
  // bits above the word index match BASE. This avoids a 32-bit overflow on
  // BASE+DEPTH*4 for a window at the top of the address map.
  assign w_in_range = (i_a_address[31:AW+2] == BASE[31:AW+2]);
  assign w_index    = i_a_address[2 +: AW];

  always_comb begin
    w_align_mask = 2'b11;
    case (i_a_size)
      2'd0:    w_align_mask = 2'b00;
      2'd1:    w_align_mask = 2'b01;
      default: w_align_mask = 2'b11;
    endcase
  end

  assign w_aligned = ((i_a_address[1:0] & w_align_mask) == 2'b00);
  assign w_size_ok = (i_a_size != 2'd3);
  assign w_op_ok   = (i_a_opcode == PUT_FULL) || (i_a_opcode == PUT_PARTIAL) ||
                     (i_a_opcode == GET);
  assign w_denied  = ~(w_in_range & w_aligned & w_size_ok & w_op_ok);

  // Atomics carry data back, so even denied ones answer with AccessAckData
  assign w_data_op = (i_a_opcode == GET) || (i_a_opcode == ARITHMETIC_DATA) ||
                     (i_a_opcode == LOGICAL_DATA);

  assign w_wr_en   = w_a_fire && !w_denied && !w_data_op;
  assign w_rd_word = r_mem[w_index];

  always_comb begin
    w_resp         = '0;
    w_resp.opcode  = w_data_op ? ACCESS_ACK_DATA : ACCESS_ACK;
    w_resp.size    = i_a_size;
    w_resp.denied  = w_denied;
    w_resp.corrupt = w_denied & w_data_op;
    w_resp.data    = (w_data_op && !w_denied) ? w_rd_word : 32'd0;
  end

  // Storage is not reset; the write lands on the accepting edge, so a Get in
  // the next cycle already sees it.
  always_ff @(posedge i_clock) begin
    if (w_wr_en) r_mem[w_index] <= byte_merge(r_mem[w_index], i_a_data, i_a_mask);
  end

  tl_ul_resp_fifo #(
    .W (PW)
  ) u_resp_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_push    (w_a_fire),
    .i_data    ({i_a_source, w_resp}),
    .o_full    (w_fifo_full),
    .o_valid   (o_d_valid),
    .o_data    (w_head_payload),
    .i_pop     (i_d_ready)
  );

  assign w_head_resp = resp_t'(w_head_payload[RW-1:0]);
  assign o_d_source  = w_head_payload[PW-1 -: SOURCE_W];
  assign o_d_opcode  = w_head_resp.opcode;
  assign o_d_size    = w_head_resp.size;
  assign o_d_denied  = w_head_resp.denied;
  assign o_d_corrupt = w_head_resp.corrupt;
  assign o_d_data    = w_head_resp.data;
  assign o_d_param   = 2'b00;

  assign w_unused = ^i_a_param;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
module tb_tl_ul_sram_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 256;
  localparam int          SW    = 2;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source;
  logic [31:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [1:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied;
  logic          d_corrupt;
  logic [31:0]   d_data;

  tl_ul_sram_responder #(
    .BASE     (BASE),
    .DEPTH    (DEPTH),
    .SOURCE_W (SW)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_opcode  (a_opcode),
    .i_a_param   (a_param),
    .i_a_size    (a_size),
    .i_a_source  (a_source),
    .i_a_address (a_address),
    .i_a_mask    (a_mask),
    .i_a_data    (a_data),
    .o_d_valid   (d_valid),
    .i_d_ready   (d_ready),
    .o_d_opcode  (d_opcode),
    .o_d_param   (d_param),
    .o_d_size    (d_size),
    .o_d_source  (d_source),
    .o_d_denied  (d_denied),
    .o_d_corrupt (d_corrupt),
    .o_d_data    (d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic          den;
    logic          cor;
    logic [31:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl_mem [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  longint      last_fire_t;
  longint      first_fire_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, written from the protocol rules rather than the RTL
  task automatic apply_model(input logic [2:0] op, input logic [1:0] size,
                             input logic [SW-1:0] src, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] data,
                             output exp_t e);
    longint a;
    bit     in_range, aligned, legal_op;
    int     idx;
    a        = longint'(addr);
    in_range = (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 4);
    aligned  = (a % (longint'(1) << size)) == 0;
    legal_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    idx      = in_range ? int'((a - longint'(BASE)) / 4) : 0;
    e.op     = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 : 3'd0;
    e.size   = size;
    e.src    = src;
    e.den    = !(in_range && aligned && size <= 2'd2 && legal_op);
    e.cor    = e.den && (e.op == 3'd1);
    e.data   = (e.op == 3'd1 && !e.den) ? mdl_mem[idx] : 32'd0;
    if (!e.den && op != 3'd4) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mdl_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] size,
                      input logic [SW-1:0] src, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data);
    exp_t e;
    int   waited;
    waited    = 0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_param   = 3'($urandom_range(0, 7));
    @(negedge clk);
    while (!a_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!a_ready) begin
      check_eq("a_ready_timeout", a_ready, 1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    apply_model(op, size, src, addr, mask, data, e);
    exp_q.push_back(e);
    last_fire_t = $time;
    #1;
    a_valid = 1'b0;
  endtask

  // Scoreboard: compare each D handshake against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_resp", d_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("resp: op=%0d size=%0d src=%0d denied=%0b corrupt=%0b data=%h",
                 d_opcode, d_size, d_source, d_denied, d_corrupt, d_data);
        check_eq("d_opcode", d_opcode, mon_e.op);
        check_eq("d_size", d_size, mon_e.size);
        check_eq("d_source", d_source, mon_e.src);
        check_eq("d_denied", d_denied, mon_e.den);
        check_eq("d_corrupt", d_corrupt, mon_e.cor);
        check_eq("d_data", d_data, mon_e.data);
        check_eq("d_param", d_param, 0);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_opcode  = '0;
    a_param   = '0;
    a_size    = '0;
    a_source  = '0;
    a_address = '0;
    a_mask    = '0;
    a_data    = '0;
    d_ready   = 1'b1;

    // Reset state
    #2;
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_d_opcode", d_opcode, 0);
    check_eq("rst_d_data", d_data, 0);
    check_eq("rst_d_denied", d_denied, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_a_ready", a_ready, 1);
    @(posedge clk); #1;

    // Write, read back, partial write, latency one cycle after each fire
    send(3'd0, 2'd2, 2'd1, BASE + 8, 4'hF, 32'hDEADBEEF);
    check_eq("lat_put", d_valid, 1);
    @(posedge clk); #1;
    send(3'd4, 2'd2, 2'd2, BASE + 8, 4'hF, 32'h0);
    check_eq("lat_get", d_valid, 1);
    send(3'd1, 2'd2, 2'd3, BASE + 8, 4'b0010, 32'h0000_5500);
    send(3'd4, 2'd2, 2'd0, BASE + 8, 4'hF, 32'h0);
    send(3'd4, 2'd0, 2'd1, BASE + 9, 4'b0010, 32'h0);

    // Error cases
    send(3'd4, 2'd2, 2'd0, BASE + DEPTH * 4, 4'hF, 32'h0);
    send(3'd0, 2'd2, 2'd1, BASE, 4'hF, 32'h11223344);
    send(3'd0, 2'd2, 2'd2, BASE + 2, 4'hF, 32'hFFFFFFFF);
    send(3'd4, 2'd2, 2'd3, BASE, 4'hF, 32'h0);
    send(3'd2, 2'd2, 2'd0, BASE, 4'hF, 32'h0);
    send(3'd6, 2'd2, 2'd1, BASE, 4'hF, 32'h0);
    send(3'd4, 2'd1, 2'd2, BASE + 1, 4'h3, 32'h0);
    send(3'd4, 2'd3, 2'd3, BASE, 4'hF, 32'h0);
    send(3'd4, 2'd2, 2'd0, BASE - 4, 4'hF, 32'h0);

    // Backpressure: two accepted, third stalls until the queue drains
    repeat (3) @(posedge clk);
    #1 d_ready = 1'b0;
    send(3'd4, 2'd2, 2'd1, BASE + 8, 4'hF, 32'h0);
    send(3'd4, 2'd2, 2'd2, BASE, 4'hF, 32'h0);
    fork
      send(3'd4, 2'd2, 2'd3, BASE + 8, 4'hF, 32'h0);
      begin
        repeat (2) begin
          @(negedge clk);
          check_eq("bp_a_ready", a_ready, 0);
          check_eq("bp_d_valid", d_valid, 1);
          check_eq("bp_hold_data", d_data, 32'hDEAD55EF);
          check_eq("bp_hold_src", d_source, 1);
        end
        @(posedge clk); #1 d_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check_eq("bp_drained", exp_q.size(), 0);

    // Reset with responses pending: queue flushed, memory kept
    @(posedge clk); #1 d_ready = 1'b0;
    send(3'd4, 2'd2, 2'd1, BASE, 4'hF, 32'h0);
    send(3'd4, 2'd2, 2'd2, BASE + 8, 4'hF, 32'h0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_d_valid", d_valid, 0);
    check_eq("mid_rst_d_data", d_data, 0);
    check_eq("mid_rst_d_source", d_source, 0);
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_a_ready", a_ready, 1);
    check_eq("post_rst_d_valid", d_valid, 0);
    d_ready = 1'b1;
    @(posedge clk); #1;
    send(3'd4, 2'd2, 2'd3, BASE, 4'hF, 32'h0);

    // Streaming: 64 writes then 64 reads, one request per cycle
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      send(3'd0, 2'd2, SW'(i), BASE + 32'(4 * (i + 32)), 4'hF, $urandom);
      if (i == 0) first_fire_t = last_fire_t;
    end
    for (int i = 0; i < 64; i++)
      send(3'd4, 2'd2, SW'(i + 1), BASE + 32'(4 * (i + 32)), 4'hF, 32'h0);
    check_eq("stream_cycles", 32'((last_fire_t - first_fire_t) / 10), 127);
    repeat (4) @(negedge clk);
    check_eq("stream_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
